// File: rtl/bus_arbiter_n.sv
// System bus arbiter: fixed-priority or round-robin grant of one master at a time,
// gated by all-slaves-ready, with optional hold-limit preemption.
module bus_arbiter_n #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned MODE        = 0,
  parameter int unsigned MAX_HOLD    = 16,
  parameter int unsigned MW          = ($clog2(NUM_MASTERS) > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_SLAVES-1:0]  sready,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MW-1:0]          msel,
  output logic                   bus_busy,
  output logic                   preempt
);

  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {StIdle, StOwned} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          msel_q, msel_d;
  logic                   busy_q, busy_d;
  logic                   preempt_q, preempt_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]          hold_q, hold_d;

  logic                   all_ready;
  logic                   owner_req;
  logic                   others_req;
  logic [MW-1:0]          win;
  logic                   win_found;

  assign all_ready  = &sready;
  assign owner_req  = breq[msel_q];
  // In OWNED, grant_q is exactly the owner bit, so masking it leaves the competitors.
  assign others_req = |(breq & ~grant_q);

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!win_found && breq[i]) begin
          win       = MW'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        if (!win_found && breq[(32'(rr_ptr_q) + k) % NUM_MASTERS]) begin
          win       = MW'((32'(rr_ptr_q) + k) % NUM_MASTERS);
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    msel_d    = msel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found && all_ready) begin
          grant_d = NUM_MASTERS'(1) << win;
          msel_d  = win;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = StOwned;
          if (MODE == 1) begin
            rr_ptr_d = (32'(win) == NUM_MASTERS - 1) ? '0 : win + MW'(1);
          end
        end
      end
      StOwned: begin
        if (!owner_req) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (MAX_HOLD > 0 && hold_q == HW'(MAX_HOLD - 1) && others_req) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          preempt_d = 1'b1;
          state_d   = StIdle;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      msel_q    <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      msel_q    <= msel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign bgrant   = grant_q;
  assign msel     = msel_q;
  assign bus_busy = busy_q;
  assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: directed per-cycle vectors feed an expectation queue that a
// separate monitor drains one entry per clock edge.
module tb_bus_arbiter_n;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] breq;
  logic [2:0] sready;

  logic [3:0] g0, g1;
  logic [1:0] m0, m1;
  logic       b0, b1, p0, p1;

  always #5 clk = ~clk;

  // dut_fp: fixed priority, no preemption. dut_rr: round-robin, hold limit 4.
  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .MODE(0), .MAX_HOLD(0)) dut_fp (
    .clk(clk), .rstn(rstn), .breq(breq), .sready(sready),
    .bgrant(g0), .msel(m0), .bus_busy(b0), .preempt(p0)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .MODE(1), .MAX_HOLD(4)) dut_rr (
    .clk(clk), .rstn(rstn), .breq(breq), .sready(sready),
    .bgrant(g1), .msel(m1), .bus_busy(b1), .preempt(p1)
  );

  typedef struct {
    int         which;
    string      name;
    logic [3:0] g;
    logic [1:0] m;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic vec(input int which, input string name, input logic r, input logic [3:0] rq,
                     input logic [2:0] sr, input logic [3:0] eg, input logic [1:0] em,
                     input logic ep);
    exp_t e;
    @(negedge clk);
    rstn   = r;
    breq   = rq;
    sready = sr;
    e.which = which;
    e.name  = name;
    e.g     = eg;
    e.m     = em;
    e.p     = ep;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t       e;
    logic [3:0] ag;
    logic [1:0] am;
    logic       ab, ap;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ag = (e.which == 0) ? g0 : g1;
      am = (e.which == 0) ? m0 : m1;
      ab = (e.which == 0) ? b0 : b1;
      ap = (e.which == 0) ? p0 : p1;
      n_vec++;
      if (ag !== e.g || am !== e.m || ab !== (|e.g) || ap !== e.p) begin
        n_bad++;
        $display("FAIL %s dut%0d: got bgrant=%b msel=%0d busy=%b preempt=%b, want bgrant=%b msel=%0d busy=%b preempt=%b",
                 e.name, e.which, ag, am, ab, ap, e.g, e.m, |e.g, e.p);
      end
    end
  end

  initial begin
    rstn   = 1'b0;
    breq   = 4'b0000;
    sready = 3'b111;

    // Reset with all masters requesting, then first grant one edge after release.
    vec(0, "rst0", 1'b0, 4'b1111, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(0, "rst1", 1'b0, 4'b1111, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(0, "rst_rel", 1'b1, 4'b1111, 3'b111, 4'b0001, 2'd0, 1'b0);

    // Fixed priority.
    vec(0, "fp_rst", 1'b0, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(0, "fp_g2", 1'b1, 4'b1100, 3'b111, 4'b0100, 2'd2, 1'b0);
    vec(0, "fp_hold2", 1'b1, 4'b1100, 3'b111, 4'b0100, 2'd2, 1'b0);
    vec(0, "fp_rel2", 1'b1, 4'b1000, 3'b111, 4'b0000, 2'd2, 1'b0);
    vec(0, "fp_g3", 1'b1, 4'b1000, 3'b111, 4'b1000, 2'd3, 1'b0);
    vec(0, "fp_rel3", 1'b1, 4'b0000, 3'b111, 4'b0000, 2'd3, 1'b0);

    // Round-robin: everyone requests, each owner releases after 3 granted cycles.
    vec(1, "rr_rst", 1'b0, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] m;
      logic [3:0] oh;
      m  = 2'(k % 4);
      oh = 4'b0001 << m;
      for (int c = 0; c < 3; c++) vec(1, "rr_own", 1'b1, 4'b1111, 3'b111, oh, m, 1'b0);
      vec(1, "rr_gap", 1'b1, 4'b1111 & ~oh, 3'b111, 4'b0000, m, 1'b0);
    end

    // Slave gating on new grants only.
    vec(0, "sg_rst", 1'b0, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(0, "sg_block0", 1'b1, 4'b0010, 3'b101, 4'b0000, 2'd0, 1'b0);
    vec(0, "sg_block1", 1'b1, 4'b0010, 3'b101, 4'b0000, 2'd0, 1'b0);
    vec(0, "sg_grant", 1'b1, 4'b0010, 3'b111, 4'b0010, 2'd1, 1'b0);
    vec(0, "sg_hold0", 1'b1, 4'b0010, 3'b110, 4'b0010, 2'd1, 1'b0);
    vec(0, "sg_hold1", 1'b1, 4'b0010, 3'b110, 4'b0010, 2'd1, 1'b0);
    vec(0, "sg_rel", 1'b1, 4'b0000, 3'b110, 4'b0000, 2'd1, 1'b0);

    // Preemption after 4 granted cycles while master 1 waits.
    vec(1, "pe_rst", 1'b0, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(1, "pe_g0", 1'b1, 4'b0001, 3'b111, 4'b0001, 2'd0, 1'b0);
    for (int c = 0; c < 3; c++) vec(1, "pe_hold", 1'b1, 4'b0011, 3'b111, 4'b0001, 2'd0, 1'b0);
    vec(1, "pe_pulse", 1'b1, 4'b0011, 3'b111, 4'b0000, 2'd0, 1'b1);
    vec(1, "pe_g1", 1'b1, 4'b0011, 3'b111, 4'b0010, 2'd1, 1'b0);
    vec(1, "pe_rel1", 1'b1, 4'b0000, 3'b111, 4'b0000, 2'd1, 1'b0);
    // Lone master never preempted; pointer is 2, search wraps to master 0.
    vec(1, "lone_g0", 1'b1, 4'b0001, 3'b111, 4'b0001, 2'd0, 1'b0);
    for (int c = 0; c < 20; c++) vec(1, "lone_hold", 1'b1, 4'b0001, 3'b111, 4'b0001, 2'd0, 1'b0);
    vec(1, "lone_rel", 1'b1, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);

    // Reset mid-grant must drop the grant and rewind the round-robin pointer.
    vec(1, "mr_rst", 1'b0, 4'b0000, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(1, "mr_g2", 1'b1, 4'b0100, 3'b111, 4'b0100, 2'd2, 1'b0);
    vec(1, "mr_hit", 1'b0, 4'b0100, 3'b111, 4'b0000, 2'd0, 1'b0);
    vec(1, "mr_g0", 1'b1, 4'b1111, 3'b111, 4'b0001, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
